note_hit_judge: RTL and testbench

- Consumer at the drain end of the note-lane shift register chain.
- On each lane `shift` strobe, samples the note bit leaving the judgment position.
- Opens a timing window for that note and judges the player's drum press inside it as HIT or MISS.
- Maintains score, current combo and best combo for the display/score path. One instance per lane.

---
 rtl/note_hit_judge.sv | 162 ++++++++++++++++
 tb/tb_note_hit_judge.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/note_hit_judge.sv
// Judges one note lane: catches notes leaving the lane shifter, opens a
// timing window for each one, classifies the player's press as HIT / MISS /
// stray, and keeps score, combo and best combo for the display path.
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous active-high reset
//   shift      one-cycle strobe, lane shifter advances
//   note_in    note bit at the judgment position, qualified by shift
//   hit        synchronised drum key level (edge-detected here)
//   hit_ok     one-cycle pulse, note judged HIT
//   miss       one-cycle pulse, note judged MISS
//   stray      one-cycle pulse, press with no note pending
//   score      accumulated score (saturating)
//   combo      consecutive HITs since the last MISS (saturating)
//   max_combo  highest combo since reset
module note_hit_judge #(
    parameter int unsigned WINDOW       = 4,
    parameter int unsigned SCORE_W      = 16,
    parameter int unsigned COMBO_W      = 8,
    parameter int unsigned BASE_POINTS  = 10,
    parameter int unsigned BONUS_POINTS = 5,
    parameter int unsigned BONUS_COMBO  = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               shift,
    input  logic               note_in,
    input  logic               hit,
    output logic               hit_ok,
    output logic               miss,
    output logic               stray,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo,
    output logic [COMBO_W-1:0] max_combo
);

    localparam int unsigned TIMER_W = $clog2(WINDOW + 1);
    localparam int unsigned SUM_W   = SCORE_W + 1;

    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(WINDOW - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX    = '1;
    localparam logic [COMBO_W-1:0] COMBO_MAX    = '1;
    localparam logic [SUM_W-1:0]   PTS_PLAIN    = SUM_W'(BASE_POINTS);
    localparam logic [SUM_W-1:0]   PTS_BONUS    = SUM_W'(BASE_POINTS + BONUS_POINTS);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 hit_q;

    logic                 press;
    logic                 arrive;
    logic                 judge_hit;
    logic                 judge_miss;
    logic                 judge_stray;

    logic                 bonus;
    logic [SUM_W-1:0]     points;
    logic [SUM_W-1:0]     score_sum;
    logic [SCORE_W-1:0]   score_hit;
    logic [COMBO_W-1:0]   combo_hit;

    assign press  = hit & ~hit_q;
    assign arrive = shift & note_in;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next state and judgment; a press in PENDING always belongs to the older note
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        judge_hit   = 1'b0;
        judge_miss  = 1'b0;
        judge_stray = 1'b0;
        case (state_q)
            IDLE: begin
                if (arrive && press) begin
                    judge_hit = 1'b1;
                end else if (arrive) begin
                    state_d = PENDING;
                    timer_d = TIMER_RELOAD;
                end else if (press) begin
                    judge_stray = 1'b1;
                end
            end
            PENDING: begin
                if (press) begin
                    judge_hit = 1'b1;
                    if (arrive) begin
                        timer_d = TIMER_RELOAD;
                    end else begin
                        state_d = IDLE;
                        timer_d = '0;
                    end
                end else if (arrive) begin
                    judge_miss = 1'b1;
                    timer_d    = TIMER_RELOAD;
                end else if (timer_q == '0) begin
                    judge_miss = 1'b1;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Score/combo arithmetic for a HIT; one extra bit catches overflow for clamping
    always_comb begin
        bonus     = 32'(combo) >= BONUS_COMBO;
        points    = bonus ? PTS_BONUS : PTS_PLAIN;
        score_sum = {1'b0, score} + points;
        score_hit = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
        combo_hit = (combo == COMBO_MAX) ? combo : combo + COMBO_W'(1);
    end

    // Registered pulses, counters and key history
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_q     <= 1'b1;
            hit_ok    <= 1'b0;
            miss      <= 1'b0;
            stray     <= 1'b0;
            score     <= '0;
            combo     <= '0;
            max_combo <= '0;
        end else begin
            hit_q  <= hit;
            hit_ok <= judge_hit;
            miss   <= judge_miss;
            stray  <= judge_stray;
            if (judge_hit) begin
                score <= score_hit;
                combo <= combo_hit;
                if (combo_hit > max_combo) begin
                    max_combo <= combo_hit;
                end
            end else if (judge_miss) begin
                combo <= '0;
            end
        end
    end

endmodule

// File: tb/tb_note_hit_judge.sv
// Bench for note_hit_judge: directed scenarios plus random lane traffic,
// checked every cycle against an event-level reference model. A second
// instance with an 8-bit score exercises score saturation.
module tb_note_hit_judge;

    localparam int WINDOW = 4;

    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic        shift   = 1'b0;
    logic        note_in = 1'b0;
    logic        hit     = 1'b1;

    logic        a_hit_ok, a_miss, a_stray;
    logic [15:0] a_score;
    logic [7:0]  a_combo, a_max;
    logic        b_hit_ok, b_miss, b_stray;
    logic [7:0]  b_score;
    logic [7:0]  b_combo, b_max;

    note_hit_judge dut_a (
        .clock(clock), .reset(reset), .shift(shift), .note_in(note_in), .hit(hit),
        .hit_ok(a_hit_ok), .miss(a_miss), .stray(a_stray),
        .score(a_score), .combo(a_combo), .max_combo(a_max)
    );

    note_hit_judge #(.SCORE_W(8)) dut_b (
        .clock(clock), .reset(reset), .shift(shift), .note_in(note_in), .hit(hit),
        .hit_ok(b_hit_ok), .miss(b_miss), .stray(b_stray),
        .score(b_score), .combo(b_combo), .max_combo(b_max)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Reference model: tracks the arrival cycle of the pending note directly
    bit m_pend = 0;
    int m_arr  = 0;
    int cyc    = 0;
    bit m_hq   = 1;
    bit e_hit = 0, e_miss = 0, e_stray = 0;
    int e_score_a = 0, e_score_b = 0, e_combo = 0, e_max = 0;

    function automatic int min2(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

    task automatic model(input bit rst, input bit sh, input bit nt, input bit h);
        bit press, arrive, had, jh, jm, js;
        int pts;
        if (rst) begin
            m_pend = 0; m_hq = 1;
            e_hit = 0; e_miss = 0; e_stray = 0;
            e_score_a = 0; e_score_b = 0; e_combo = 0; e_max = 0;
            return;
        end
        press  = h && !m_hq;
        arrive = sh && nt;
        m_hq   = h;
        jh = 0; jm = 0; js = 0;
        had = m_pend;
        if (had) begin
            if (press) begin
                jh = 1; m_pend = 0;
            end else if (arrive || (cyc - m_arr == WINDOW)) begin
                jm = 1; m_pend = 0;
            end
        end
        if (arrive) begin
            if (!had && press) jh = 1;
            else begin
                m_pend = 1; m_arr = cyc;
            end
        end else if (press && !had) begin
            js = 1;
        end
        if (jh) begin
            pts = 10 + ((e_combo >= 10) ? 5 : 0);
            e_score_a = min2(e_score_a + pts, 65535);
            e_score_b = min2(e_score_b + pts, 255);
            e_combo   = min2(e_combo + 1, 255);
            if (e_combo > e_max) e_max = e_combo;
        end else if (jm) begin
            e_combo = 0;
        end
        e_hit = jh; e_miss = jm; e_stray = js;
    endtask

    // One cycle: check outputs of the last edge, then drive and model the next
    task automatic step(input bit rst, input bit sh, input bit nt, input bit h);
        @(negedge clock);
        check("hit_ok",    32'(a_hit_ok), 32'(e_hit));
        check("miss",      32'(a_miss),   32'(e_miss));
        check("stray",     32'(a_stray),  32'(e_stray));
        check("score",     32'(a_score),  32'(e_score_a));
        check("combo",     32'(a_combo),  32'(e_combo));
        check("max_combo", 32'(a_max),    32'(e_max));
        check("b_hit_ok",  32'(b_hit_ok), 32'(e_hit));
        check("b_miss",    32'(b_miss),   32'(e_miss));
        check("b_score8",  32'(b_score),  32'(e_score_b));
        check("b_combo",   32'(b_combo),  32'(e_combo));
        reset = rst; shift = sh; note_in = nt; hit = h;
        model(rst, sh, nt, h);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        // Key held through reset release: no stray; then a lone press is stray
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        idle(3);

        // Press at every offset from arrival, including just outside the window
        for (int d = 0; d <= WINDOW + 2; d++) begin
            for (int c = 0; c <= d; c++) step(0, c == 0, c == 0, c == d);
            idle(WINDOW + 3);
        end

        // Eleven-plus consecutive hits reach the bonus, then a miss
        for (int n = 0; n < 12; n++) begin
            step(0, 1, 1, 0);
            step(0, 0, 0, 1);
            step(0, 0, 0, 0);
        end
        step(0, 1, 1, 0);
        idle(WINDOW + 3);

        // Back-to-back arrivals: replace without press, then press with arrival
        step(0, 1, 1, 0); step(0, 0, 0, 0); step(0, 1, 1, 0);
        step(0, 0, 0, 0); step(0, 0, 0, 1); step(0, 0, 0, 0);
        step(0, 1, 1, 0); step(0, 1, 1, 1); step(0, 0, 0, 0);
        idle(WINDOW + 3);

        // Reset while a note is pending
        step(0, 1, 1, 0); step(0, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0);
        idle(WINDOW + 3);

        // Long hit streak saturates combo and the 8-bit score
        for (int n = 0; n < 300; n++) begin
            step(0, 1, 1, 0);
            step(0, 0, 0, 1);
            step(0, 0, 0, 0);
        end

        // Random lane traffic with varying note and press densities
        for (int ph = 0; ph < 4; ph++) begin
            int note_pct = 10 + ph * 20;
            int key_pct  = 15 + ph * 10;
            bit h = 0;
            for (int i = 0; i < 1500; i++) begin
                bit sh, nt, rst;
                sh  = ($urandom_range(99) < 40);
                nt  = ($urandom_range(99) < note_pct);
                rst = ($urandom_range(999) < 3);
                if ($urandom_range(99) < key_pct) h = ~h;
                step(rst, sh, nt, h);
            end
        end

        step(0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
